// File: rtl/sbox_sequencer.sv
// -----------------------------------------------------------------------------
// sbox_sequencer
//
// Time-multiplexed DES S-box substitution followed by the P permutation.
// A 48-bit key-mixed expansion word is accepted over a valid/ready handshake,
// the eight S-box results are captured one nibble per clock into a 32-bit
// S-word, and the permuted f-function result is offered downstream over a
// second valid/ready handshake.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst        in   1   synchronous active-high reset
//   in         in  48   E(R) xor K, bit 1 is the MSB (DES numbering)
//   in_valid   in   1   upstream offers a word on in
//   in_ready   out  1   block is idle and will take a word
//   out        out 32   P(S1..S8), bit 1 is the MSB
//   out_valid  out  1   out holds a finished result
//   out_ready  in   1   downstream consumes out
//
// Also contains the s1box..s8box lookups. Each takes a 6-bit group (bit 1 is
// the MSB) and returns a 4-bit value using row = bits 1,6 and column = bits
// 2..5. Every table is packed as 64 nibbles, entry 0 in the top nibble,
// entries ordered row by row.
// -----------------------------------------------------------------------------

module s1box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   // Entry idx sits at bit 255-4*idx, which equals {~idx, 2'b11}.
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s2box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s3box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s4box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s5box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s6box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s7box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module s8box (
   input  logic [1:6] a,
   output logic [1:4] y
);
   localparam logic [255:0] TABLE =
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;
   logic [5:0] idx;
   assign idx = {a[1], a[6], a[2:5]};
   assign y = TABLE[{~idx, 2'b11} -: 4];
endmodule

module sbox_sequencer (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:48] in,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [1:32] out,
   output logic        out_valid,
   input  logic        out_ready
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t      state;
   state_t      state_next;
   logic [2:0]  cnt;
   logic [1:48] hold;
   logic [1:32] sword;
   logic [1:32] sall;

   // All eight lookups run off the holding register; cnt decides which
   // nibble gets captured on a given edge.
   s1box u_s1 (.a(hold[1:6]),   .y(sall[1:4]));
   s2box u_s2 (.a(hold[7:12]),  .y(sall[5:8]));
   s3box u_s3 (.a(hold[13:18]), .y(sall[9:12]));
   s4box u_s4 (.a(hold[19:24]), .y(sall[13:16]));
   s5box u_s5 (.a(hold[25:30]), .y(sall[17:20]));
   s6box u_s6 (.a(hold[31:36]), .y(sall[21:24]));
   s7box u_s7 (.a(hold[37:42]), .y(sall[25:28]));
   s8box u_s8 (.a(hold[43:48]), .y(sall[29:32]));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic. DONE never accepts directly; a new word always waits
   // for the following IDLE cycle.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid)     state_next = RUN;
         RUN:  if (cnt == 3'd7)  state_next = DONE;
         DONE: if (out_ready)    state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Handshake outputs are pure decodes of the state register.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // Datapath: latch the input word on accept, then write one S-box nibble
   // per RUN cycle. cnt wraps 7->0 on the same edge that enters DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 3'd0;
         hold  <= 48'd0;
         sword <= 32'd0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  hold <= in;
                  cnt  <= 3'd0;
               end
            end
            RUN: begin
               cnt <= cnt + 3'd1;
               case (cnt)
                  3'd0: sword[1:4]   <= sall[1:4];
                  3'd1: sword[5:8]   <= sall[5:8];
                  3'd2: sword[9:12]  <= sall[9:12];
                  3'd3: sword[13:16] <= sall[13:16];
                  3'd4: sword[17:20] <= sall[17:20];
                  3'd5: sword[21:24] <= sall[21:24];
                  3'd6: sword[25:28] <= sall[25:28];
                  default: sword[29:32] <= sall[29:32];
               endcase
            end
            default: begin
            end
         endcase
      end
   end

   // P permutation is plain wiring from the registered S-word, so out is
   // stable for as long as DONE lasts.
   assign out = {sword[16], sword[7],  sword[20], sword[21],
                 sword[29], sword[12], sword[28], sword[17],
                 sword[1],  sword[15], sword[23], sword[26],
                 sword[5],  sword[18], sword[31], sword[10],
                 sword[2],  sword[8],  sword[24], sword[14],
                 sword[32], sword[27], sword[3],  sword[9],
                 sword[19], sword[13], sword[30], sword[6],
                 sword[22], sword[11], sword[4],  sword[25]};

endmodule

// File: tb/tb_sbox_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sbox_sequencer
//
// Self-checking bench for sbox_sequencer. Expected results come from a
// reference model built from the DES S-box tables and P table written as
// plain integer arrays; known vectors are also checked against constants.
// -----------------------------------------------------------------------------

module tb_sbox_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:48] din = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [1:32] dout;
   logic        out_valid;
   logic        out_ready = 1'b1;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   sbox_sequencer dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out       (dout),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   // 10 time-unit clock; cyc counts rising edges.
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop in case something hangs.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // DES S-boxes, [box][row][column].
   int sbt [0:7][0:3][0:15] = '{
      '{'{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7},
        '{0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8},
        '{4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0},
        '{15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13}},
      '{'{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10},
        '{3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5},
        '{0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15},
        '{13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9}},
      '{'{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8},
        '{13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1},
        '{13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7},
        '{1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12}},
      '{'{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15},
        '{13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9},
        '{10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4},
        '{3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14}},
      '{'{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9},
        '{14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6},
        '{4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14},
        '{11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3}},
      '{'{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11},
        '{10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8},
        '{9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6},
        '{4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13}},
      '{'{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1},
        '{13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6},
        '{1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2},
        '{6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12}},
      '{'{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7},
        '{1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2},
        '{7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8},
        '{2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}}
   };

   int ptab [0:31] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                       2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};

   // Reference f-function core: substitute each 6-bit group, then permute.
   function automatic logic [31:0] model_f(input logic [47:0] w);
      logic [31:0] sw;
      logic [31:0] r;
      int grp, row, col;
      sw = '0;
      for (int i = 0; i < 8; i++) begin
         grp = int'((w >> (42 - 6 * i)) & 48'h3F);
         row = ((grp >> 4) & 2) | (grp & 1);
         col = (grp >> 1) & 15;
         sw  = sw | (32'(sbt[i][row][col]) << (28 - 4 * i));
      end
      r = '0;
      for (int j = 1; j <= 32; j++) begin
         r[32 - j] = sw[32 - ptab[j - 1]];
      end
      return r;
   endfunction

   function automatic logic [47:0] rand_word();
      return {16'($urandom), $urandom};
   endfunction

   // Offer one word, wait for it to be accepted and then for out_valid.
   // lat counts edges between the accept edge and out_valid being seen.
   task automatic send_word(input logic [47:0] w, output logic [31:0] res,
                            output int lat, output bit ok);
      int guard;
      guard = 0;
      din = w;
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      ok  = out_valid;
      res = dout;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b1;
      din = 48'h6117BA866527;
      repeat (2) begin
         @(posedge clk); #1;
      end
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 32'h0) begin
         failures++;
         $display("[TB] FAIL reset_state: in_ready=%b out_valid=%b out=%h, want 1 0 00000000",
                  in_ready, out_valid, dout);
      end
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         failures++;
         $display("[TB] FAIL reset_no_accept: in_ready=%b out_valid=%b, want 1 0",
                  in_ready, out_valid);
      end
   endtask

   task automatic test_vectors();
      logic [31:0] res;
      int lat;
      bit ok;
      out_ready = 1'b1;

      send_word(48'h000000000000, res, lat, ok);
      checks++;
      if (!ok || res !== 32'hD8D8DBBC || lat !== 8) begin
         failures++;
         $display("[TB] FAIL all_zero: out=%h lat=%0d valid=%b, want D8D8DBBC lat=8",
                  res, lat, ok);
      end

      send_word(48'h6117BA866527, res, lat, ok);
      checks++;
      if (!ok || res !== 32'h234AA9BB || lat !== 8) begin
         failures++;
         $display("[TB] FAIL round1_vector: out=%h lat=%0d valid=%b, want 234AA9BB lat=8",
                  res, lat, ok);
      end

      for (int n = 0; n < 12; n++) begin
         logic [47:0] w;
         logic [31:0] exp_r;
         w = (n == 0) ? 48'hFFFFFFFFFFFF : rand_word();
         exp_r = model_f(w);
         send_word(w, res, lat, ok);
         checks++;
         if (!ok || res !== exp_r || lat !== 8) begin
            failures++;
            $display("[TB] FAIL random_%0d in=%h: out=%h lat=%0d valid=%b, want %h lat=8",
                     n, w, res, lat, ok, exp_r);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      logic [31:0] res;
      logic [31:0] held;
      logic [47:0] w;
      int lat;
      bit ok;
      int bad;
      repeat (2) begin
         @(posedge clk); #1;
      end
      out_ready = 1'b0;
      w = rand_word();
      send_word(w, res, lat, ok);
      checks++;
      if (!ok || res !== model_f(w)) begin
         failures++;
         $display("[TB] FAIL bp_result: out=%h valid=%b, want %h", res, ok, model_f(w));
      end
      held = res;
      bad = 0;
      for (int c = 0; c < 20; c++) begin
         din = rand_word();
         in_valid = 1'b1;
         @(posedge clk); #1;
         checks++;
         if (dout !== held || in_ready !== 1'b0 || out_valid !== 1'b1) begin
            failures++;
            bad++;
            if (bad < 4)
               $display("[TB] FAIL bp_hold cycle %0d: out=%h in_ready=%b out_valid=%b, want %h 0 1",
                        c, dout, in_ready, out_valid, held);
         end
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         failures++;
         $display("[TB] FAIL bp_release: out_valid=%b in_ready=%b, want 0 1 (no accept in DONE)",
                  out_valid, in_ready);
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      logic [47:0] words [0:1];
      logic [31:0] got [0:1];
      int acc [0:1];
      int nacc, nres;
      words[0] = 48'h000000000000;
      words[1] = 48'h6117BA866527;
      nacc = 0;
      nres = 0;
      out_ready = 1'b1;
      din = words[0];
      in_valid = 1'b1;
      for (int c = 0; c < 40; c++) begin
         if (in_ready && in_valid && nacc < 2) begin
            acc[nacc] = cyc;
            nacc++;
         end
         if (out_valid && nres < 2) begin
            got[nres] = dout;
            nres++;
         end
         @(posedge clk); #1;
         if (nacc == 1) din = words[1];
         if (nacc == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      checks++;
      if (nres !== 2 || got[0] !== 32'hD8D8DBBC || got[1] !== 32'h234AA9BB) begin
         failures++;
         $display("[TB] FAIL b2b_results: count=%0d first=%h second=%h, want 2 D8D8DBBC 234AA9BB",
                  nres, got[0], got[1]);
      end
      checks++;
      if (nacc !== 2 || (acc[1] - acc[0]) !== 10) begin
         failures++;
         $display("[TB] FAIL b2b_spacing: accepts=%0d gap=%0d, want 2 gap=10",
                  nacc, (nacc == 2) ? acc[1] - acc[0] : -1);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] res;
      int lat;
      bit ok;
      int guard;
      int pulses;
      guard = 0;
      out_ready = 1'b1;
      din = rand_word();
      in_valid = 1'b1;
      while (!in_ready && guard < 50) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      // Four RUN edges leave cnt at 4.
      repeat (4) begin
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || dout !== 32'h0) begin
         failures++;
         $display("[TB] FAIL midrst_idle: in_ready=%b out_valid=%b out=%h, want 1 0 00000000",
                  in_ready, out_valid, dout);
      end
      pulses = 0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("[TB] FAIL midrst_no_valid: out_valid pulses=%0d, want 0", pulses);
      end
      send_word(48'h6117BA866527, res, lat, ok);
      checks++;
      if (!ok || res !== 32'h234AA9BB || lat !== 8) begin
         failures++;
         $display("[TB] FAIL midrst_next_word: out=%h lat=%0d valid=%b, want 234AA9BB lat=8",
                  res, lat, ok);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      $display("[TB] starting sbox_sequencer bench");
      test_reset();
      test_vectors();
      test_backpressure();
      test_back_to_back();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
